// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// Sizes the prefix-length state and fixes the MATCH encoding.
package seq_det_pkg;

  localparam logic [2:0] DEF_PATTERN = 3'b101;

  function automatic int state_w(input int len);
    return $clog2(len + 1);
  endfunction

  // MATCH is the state whose prefix length equals the pattern length
  function automatic int match_k(input int len);
    return len;
  endfunction

endpackage

// File: rtl/seq_next_state.sv
// Prefix-suffix search: longest pattern prefix that ends the
// window formed by the history register plus the incoming bit.
module seq_next_state
  import seq_det_pkg::*;
#(
  parameter int PATTERN_LEN = 3,
  localparam int SW = state_w(PATTERN_LEN)
) (
  input  logic [PATTERN_LEN-1:0] pattern_i,
  input  logic [PATTERN_LEN-2:0] history_i,
  input  logic [SW-1:0]          k_i,
  input  logic                   bit_i,
  output logic [SW-1:0]          k_o
);

  logic [PATTERN_LEN-1:0] win;
  logic [PATTERN_LEN-1:0] mask;
  logic [PATTERN_LEN-1:0] pfx;
  int                     lim;

  // A match can grow by at most one bit, which also keeps the
  // search inside the bits that have actually been consumed.
  always_comb begin
    win  = {history_i, bit_i};
    lim  = (int'(k_i) >= PATTERN_LEN) ?
           PATTERN_LEN : int'(k_i) + 1;
    k_o  = '0;
    mask = '0;
    pfx  = '0;
    for (int j = 1; j <= PATTERN_LEN; j++) begin
      mask = {PATTERN_LEN{1'b1}} >> (PATTERN_LEN - j);
      pfx  = pattern_i >> (PATTERN_LEN - j);
      if (j <= lim && (win & mask) == pfx)
        k_o = SW'(j);
    end
  end

endmodule

// File: rtl/seq_detector_moore.sv
// Moore serial pattern detector with reloadable pattern,
// overlap mode and a saturating match counter.
module seq_detector_moore
  import seq_det_pkg::*;
#(
  parameter int PATTERN_LEN = 3,
  parameter logic [PATTERN_LEN-1:0] PATTERN =
    PATTERN_LEN'(DEF_PATTERN),
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_bit,
  input  logic                         cfg_load,
  input  logic [PATTERN_LEN-1:0]       cfg_pattern,
  output logic                         out,
  output logic [state_w(PATTERN_LEN)-1:0] state_o,
  output logic [CNT_W-1:0]             match_count
);

  localparam int SW = state_w(PATTERN_LEN);
  localparam int HW = PATTERN_LEN - 1;
  localparam logic [SW-1:0] MATCH =
    SW'(match_k(PATTERN_LEN));

  logic [SW-1:0]          state_q, state_d;
  logic [HW-1:0]          hist_q, hist_d;
  logic [PATTERN_LEN-1:0] pat_q, pat_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]          k_cur, k_nxt;

  // Without overlap, a bit after MATCH is judged from empty
  assign k_cur = (!OVERLAP && state_q == MATCH) ?
                 '0 : state_q;

  seq_next_state #(
    .PATTERN_LEN(PATTERN_LEN)
  ) u_next (
    .pattern_i(pat_q),
    .history_i(hist_q),
    .k_i      (k_cur),
    .bit_i    (in_bit),
    .k_o      (k_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      hist_q  <= '0;
      pat_q   <= PATTERN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    if (cfg_load) begin
      pat_d   = cfg_pattern;
      state_d = '0;
      hist_d  = '0;
      cnt_d   = '0;
    end else if (in_valid) begin
      state_d = k_nxt;
      hist_d  = HW'({hist_q, in_bit});
      if (k_nxt == MATCH) begin
        if (cnt_q != '1)
          cnt_d = cnt_q + CNT_W'(1);
        if (!OVERLAP)
          hist_d = '0;
      end
    end
  end

  always_comb begin
    out         = (state_q == MATCH);
    state_o     = state_q;
    match_count = cnt_q;
  end

endmodule

// File: tb/tb_seq_detector_moore.sv
// Bench: stream model over the full consumed history, checked
// every cycle, plus hand-computed literal expectations.
module tb_seq_detector_moore;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       cfg_load;
  logic [2:0] cfg_a;
  logic [1:0] cfg_c;

  logic       out_a, out_b, out_c;
  logic [1:0] st_a, st_b, st_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  seq_detector_moore u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_bit(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(cfg_a), .out(out_a),
    .state_o(st_a), .match_count(cnt_a)
  );

  seq_detector_moore #(.OVERLAP(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_bit(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(cfg_a), .out(out_b),
    .state_o(st_b), .match_count(cnt_b)
  );

  seq_detector_moore #(
    .PATTERN_LEN(2), .PATTERN(2'b11),
    .OVERLAP(1'b1), .CNT_W(2)
  ) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_bit(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(cfg_c), .out(out_c),
    .state_o(st_c), .match_count(cnt_c)
  );

  // Model: n bits consumed since the last restart, newest in h[0]
  typedef struct {
    int          n;
    logic [31:0] h;
    int          k;
    int          cnt;
    logic [15:0] pat;
  } mdl_t;

  mdl_t ma, mb, mc;

  function automatic mdl_t mrst(input logic [15:0] p);
    mdl_t m;
    m.n = 0; m.h = '0; m.k = 0; m.cnt = 0; m.pat = p;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int l,
                                 input bit ovl, input int cmax,
                                 input logic b);
    mdl_t r;
    logic [31:0] msk;
    r = m;
    if (!ovl && r.k == l) begin
      r.n = 0;
      r.h = '0;
    end
    r.h = {r.h[30:0], b};
    r.n++;
    r.k = 0;
    for (int j = 1; j <= l; j++) begin
      msk = (32'd1 << j) - 32'd1;
      if (j <= r.n &&
          (r.h & msk) == 32'(r.pat >> (l - j)))
        r.k = j;
    end
    if (r.k == l && r.cnt < cmax) r.cnt++;
    return r;
  endfunction

  task automatic cmp(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      ma = mrst(16'(3'b101));
      mb = mrst(16'(3'b101));
      mc = mrst(16'(2'b11));
      armed = 1'b1;
    end else if (cfg_load) begin
      ma = mrst(16'(cfg_a));
      mb = mrst(16'(cfg_a));
      mc = mrst(16'(cfg_c));
    end else if (in_valid) begin
      ma = mstep(ma, 3, 1'b1, 255, in_bit);
      mb = mstep(mb, 3, 1'b0, 255, in_bit);
      mc = mstep(mc, 2, 1'b1, 3, in_bit);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      cmp("a_out", int'(out_a), int'(ma.k == 3));
      cmp("a_st",  int'(st_a),  ma.k);
      cmp("a_cnt", int'(cnt_a), ma.cnt);
      cmp("b_out", int'(out_b), int'(mb.k == 3));
      cmp("b_st",  int'(st_b),  mb.k);
      cmp("b_cnt", int'(cnt_b), mb.cnt);
      cmp("c_out", int'(out_c), int'(mc.k == 2));
      cmp("c_st",  int'(st_c),  mc.k);
      cmp("c_cnt", int'(cnt_c), mc.cnt);
    end
  end

  task automatic bitv(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_rst;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
    cfg_load = 1'b0; cfg_a = 3'b000; cfg_c = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp("L_rst_out", int'(out_a), 0);
    cmp("L_rst_st",  int'(st_a),  0);
    cmp("L_rst_cnt", int'(cnt_a), 0);

    // 101 then 01: overlap gives a second match
    bitv(1); bitv(0); bitv(1);
    cmp("L_101_out", int'(out_a), 1);
    cmp("L_101_st",  int'(st_a),  3);
    cmp("L_101_cnt", int'(cnt_a), 1);
    cmp("L_b101_out", int'(out_b), 1);
    bitv(0);
    cmp("L_ov4_out", int'(out_a), 0);
    cmp("L_ov4_st",  int'(st_a),  2);
    cmp("L_no4_st",  int'(st_b),  0);
    bitv(1);
    cmp("L_ov5_out", int'(out_a), 1);
    cmp("L_ov5_cnt", int'(cnt_a), 2);
    cmp("L_no5_out", int'(out_b), 0);
    cmp("L_no5_cnt", int'(cnt_b), 1);

    // idle gaps inside and after the pattern
    do_rst();
    bitv(1); idle(1); bitv(0); idle(2); bitv(1);
    idle(3);
    cmp("L_gap_out", int'(out_a), 1);
    cmp("L_gap_cnt", int'(cnt_a), 1);

    // reload mid-stream; the same-cycle bit is dropped
    do_rst();
    bitv(1); bitv(0);
    cmp("L_pre_st", int'(st_a), 2);
    cfg_load = 1'b1; cfg_a = 3'b110;
    in_valid = 1'b1; in_bit = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0; in_valid = 1'b0;
    cmp("L_ld_st",  int'(st_a),  0);
    cmp("L_ld_cnt", int'(cnt_a), 0);
    cmp("L_ld_out", int'(out_a), 0);
    bitv(1); bitv(1); bitv(0);
    cmp("L_110_out", int'(out_a), 1);
    cmp("L_110_cnt", int'(cnt_a), 1);
    bitv(1); bitv(0); bitv(1);
    cmp("L_n101_out", int'(out_a), 0);
    cmp("L_n101_cnt", int'(cnt_a), 1);

    // pattern 11, six 1s, 2-bit saturating counter
    do_rst();
    bitv(1);
    cmp("L_c1_out", int'(out_c), 0);
    cmp("L_c1_st",  int'(st_c),  1);
    bitv(1);
    cmp("L_c2_out", int'(out_c), 1);
    repeat (4) bitv(1);
    cmp("L_c6_out", int'(out_c), 1);
    cmp("L_c6_cnt", int'(cnt_c), 3);
    rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    cmp("L_crst_out", int'(out_c), 0);
    cmp("L_crst_cnt", int'(cnt_c), 0);

    // reset beats a simultaneous load
    cfg_a = 3'b011;
    rst = 1'b1; cfg_load = 1'b1;
    @(negedge clk);
    rst = 1'b0; cfg_load = 1'b0;
    bitv(1); bitv(0); bitv(1);
    cmp("L_rw_out", int'(out_a), 1);
    cmp("L_rw_cnt", int'(cnt_a), 1);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
